ifid_fetch_queue: RTL and testbench
===================================

Name: ifid_fetch_queue

Overview:
- Receiving end of the fetch→decode interface. Accepts {pc_addr, inst} pairs produced by the fetch stage and buffers them in a small in-order FIFO.
- Presents the oldest entry to decode under a valid/ready handshake.
- Back-pressures fetch with a stall when full.
- Discards all buffered entries on a branch/jump redirect (flush).

Parameters:
- DATA_W, 32, width of pc and instruction words (matches the common word width).
- DEPTH, 4, number of entries; power of 2, ≥2.
- NOP_INST, 32'h0000_0000, instruction value driven to decode when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: state clears on a rising clk edge while rst==0.
- if_valid  in  1  fetch presents a valid pair this cycle.
- if_pc  in  DATA_W  pc_addr from fetch.
- if_inst  in  DATA_W  instruction from fetch.
- if_stall  out  1  back-pressure to fetch; fetch must hold its pc while high.
- flush  in  1  redirect (jump taken); drops every entry and the current input.
- id_valid  out  1  head entry is valid.
- id_pc  out  DATA_W  pc of head entry.
- id_inst  out  DATA_W  instruction of head entry.
- id_ready  in  1  decode consumes the head this cycle.
- q_count  out  $clog2(DEPTH)+1  current occupancy, for debug and performance counting.

Behaviour:
- State: storage[DEPTH] of {pc, inst}; wr_ptr, rd_ptr each log2(DEPTH) bits, wrapping modulo DEPTH; count 0..DEPTH.
- Reset (rst==0 at edge): wr_ptr=rd_ptr=0, count=0. Storage contents are don't-care.
- Outputs after reset: id_valid=0, id_pc=0, id_inst=NOP_INST, if_stall=0, q_count=0.
- full = (count==DEPTH); empty = (count==0).
- if_stall = full. Combinational from registered count only; no dependence on id_ready.
- enq = if_valid & ~full & ~flush.
- deq = id_valid & id_ready & ~flush.
- Enqueue: storage[wr_ptr] <= {if_pc, if_inst}; wr_ptr++.
- Dequeue: rd_ptr++.
- Count: +1 on enq-only, −1 on deq-only, unchanged on both.
- Latency: an entry written at edge N is visible on id_* after edge N. No combinational bypass from if_* to id_*.
- id_valid = ~empty.
- id_pc/id_inst = storage[rd_ptr] when non-empty; 0 / NOP_INST when empty.
- Full + dequeue in the same cycle: enqueue is still blocked, because if_stall is already high. Fetch retries next cycle. No entry is lost.
- Empty + enqueue: id_valid rises the next cycle.
- Simultaneous enq and deq when 0<count<DEPTH: both happen; count unchanged.
- Flush takes priority over everything:
  - at the next edge: wr_ptr=rd_ptr=0, count=0;
  - the if_* pair presented during the flush cycle is dropped;
  - the head is not counted as consumed even if id_ready=1.
- Cycle after flush: id_valid=0, if_stall=0.
- Flush while empty: no effect beyond resetting the pointers.
- Reset mid-operation: identical to power-on reset; reset overrides flush and the handshakes.
- Pointer wrap-around: pointers wrap silently; full/empty come from count, never from pointer equality.
- No overflow or underflow is possible by construction; assertions flag enq while full and deq while empty.

Decomposition:
- Shared package gets:
  - typedef ifq_entry_t {logic [DATA_W-1:0] pc; logic [DATA_W-1:0] inst;};
  - IFQ_DEPTH default;
  - NOP_INST constant (reused by the decode stage).
- One sub-module is natural: ifq_ptr_ctrl. It holds the pointers, the count, the enq/deq/flush logic and produces full/empty.
- The storage array and output mux stay in the top module.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, then rst=1 with if_valid=0 → id_valid=0, id_inst=32'h0, if_stall=0, q_count=0 for 5 cycles.
- Single pass-through: id_ready=1; send pc=0x100, inst=0x2408_0005 for one cycle → next cycle id_valid=1, id_pc=0x100, id_inst=0x2408_0005; following cycle id_valid=0.
- Fill and stall: id_ready=0; send pc 0x0, 0x4, 0x8, 0xC, 0x10 back-to-back → if_stall=1 after the 4th, q_count=4, 0x10 not accepted. Then raise id_ready → outputs 0x0, 0x4, 0x8, 0xC in order, 0x10 accepted once if_stall drops, exactly once.
- Wrap-around: id_ready=1, continuous stream of 12 pcs 0x0..0x2C → all emerged in order, count stays ≤1, no drops or duplicates after pointers wrap 3 times.
- Flush priority: queue holds 0x40, 0x44, 0x48; assert flush with if_valid=1 (pc=0x4C) and id_ready=1 → next cycle id_valid=0, q_count=0; 0x4C never appears. Next input pc=0x200 emerges first.
- Reset mid-stream: queue holds 3 entries; assert rst=0 for one cycle with flush=0 → q_count=0, id_valid=0. Normal operation resumes with the next input.

Source files
------------

// File: rtl/ifid_fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode queue; the decode
// stage also imports this package for the NOP encoding.
package ifid_fetch_queue_pkg;

    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_DEPTH  = 4;

    // Instruction presented to decode whenever no real instruction is available.
    localparam logic [IFQ_DATA_W-1:0] IFQ_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [IFQ_DATA_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifid_fetch_queue_ptr_ctrl.sv
// Pointer and occupancy control for the fetch queue: read/write pointers,
// entry count, and the enqueue/dequeue/flush decisions. Full and empty
// come from the count, so pointer wrap-around never confuses them.
module ifq_ptr_ctrl
    import ifid_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic                       enq,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          deq;

    // Handshake decisions and next-state pointers; flush wins over both handshakes.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        enq      = if_valid & ~full & ~flush;
        deq      = ~empty & id_ready & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(enq && full));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst) !(deq && empty));

endmodule

// File: rtl/ifid_fetch_queue.sv
// Receiving end of the fetch-to-decode interface: a small in-order FIFO of
// {pc, inst} pairs with a valid/ready output, a stall back to fetch when
// full, and a flush that discards everything on a redirect.
module ifid_fetch_queue
    import ifid_fetch_queue_pkg::*;
#(
    parameter int                DATA_W   = IFQ_DATA_W,
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IFQ_NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [DATA_W-1:0]        if_pc,
    input  logic [DATA_W-1:0]        if_inst,
    output logic                     if_stall,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_pc,
    output logic [DATA_W-1:0]        id_inst,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t        storage_q [DEPTH];
    entry_t        storage_d [DEPTH];
    logic          enq;
    logic          full;
    logic          empty;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    ifq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .id_ready (id_ready),
        .flush    (flush),
        .enq      (enq),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (q_count),
        .full     (full),
        .empty    (empty)
    );

    // Write the incoming pair into the slot at the write pointer when accepted.
    always_comb begin
        storage_d = storage_q;
        if (enq) begin
            storage_d[wr_ptr] = '{pc: if_pc, inst: if_inst};
        end
    end

    // Entry storage; contents are meaningless while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        storage_q <= storage_d;
    end

    // Head-of-queue view for decode; an empty queue shows pc 0 and a NOP.
    always_comb begin
        id_valid = ~empty;
        if_stall = full;
        id_pc    = '0;
        id_inst  = NOP_INST;
        if (!empty) begin
            id_pc   = storage_q[rd_ptr].pc;
            id_inst = storage_q[rd_ptr].inst;
        end
    end

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed testbench for ifid_fetch_queue with a scoreboard queue holding
// the entries the queue should contain, head first.
module tb_ifid_fetch_queue;
    import ifid_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [2:0]  q_count;

    ifq_entry_t  sb[$];
    logic        m_blocked;
    int          checks;
    int          failures;

    ifid_fetch_queue #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_stall (if_stall),
        .flush    (flush),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .q_count  (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkInst(input logic [31:0] pc);
        return {16'h2408, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard head and occupancy.
    task automatic checkOutput();
        logic exp_valid;
        exp_valid = (sb.size() != 0);
        check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
        check("q_count", {29'b0, q_count}, 32'(sb.size()));
        check("if_stall", {31'b0, if_stall}, {31'b0, (sb.size() == DEPTH)});
        if (exp_valid) begin
            check("id_pc", id_pc, sb[0].pc);
            check("id_inst", id_inst, sb[0].inst);
        end else begin
            check("id_pc_empty", id_pc, 32'h0);
            check("id_inst_empty", id_inst, 32'h0000_0000);
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, check at the falling edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic rdy, input logic fl);
        logic m_full;
        logic m_deq;
        logic m_enq;
        rst      = r;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        @(posedge clk);
        m_full    = (sb.size() == DEPTH);
        m_blocked = 1'b0;
        if (!r || fl) begin
            sb.delete();
        end else begin
            m_deq     = (sb.size() != 0) && rdy;
            m_enq     = v && !m_full;
            m_blocked = v && m_full;
            if (m_deq) void'(sb.pop_front());
            if (m_enq) sb.push_back('{pc: pc, inst: inst});
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic send(input logic [31:0] pc, input logic rdy);
        applyStimulus(1'b1, 1'b1, pc, mkInst(pc), rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) idle(1'b1, 1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_blocked = 1'b0;
        rst       = 1'b0;
        if_valid  = 1'b0;
        if_pc     = '0;
        if_inst   = '0;
        id_ready  = 1'b0;
        flush     = 1'b0;

        $display("[TB] reset then idle");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 5);

        $display("[TB] single pass-through");
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h2408_0005, 1'b1, 1'b0);
        idle(1'b1, 2);

        $display("[TB] fill and stall");
        for (int i = 0; i < 5; i++) send(32'(i * 4), 1'b0);
        m_blocked = 1'b1;
        for (int i = 0; i < 4 && m_blocked; i++) send(32'h10, 1'b1);
        drain();
        idle(1'b1, 1);

        $display("[TB] wrap-around stream");
        for (int i = 0; i < 12; i++) send(32'(i * 4), 1'b1);
        idle(1'b1, 2);

        $display("[TB] flush priority");
        send(32'h40, 1'b0);
        send(32'h44, 1'b0);
        send(32'h48, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h4C, mkInst(32'h4C), 1'b1, 1'b1);
        send(32'h200, 1'b0);
        drain();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        $display("[TB] reset mid-stream");
        send(32'h80, 1'b0);
        send(32'h84, 1'b0);
        send(32'h88, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8C, mkInst(32'h8C), 1'b1, 1'b0);
        send(32'h300, 1'b0);
        send(32'h304, 1'b1);
        drain();
        idle(1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
